data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
//  Responder end of the data_sram_* port driven by the MEM stage: word-addressed on-chip data RAM.
//  Serves byte-enable writes and one-cycle-latency reads.
//  Counts accesses that fall outside its address window.
//  Sits at top level between the MEM stage (physical address after fixed mapping) and nothing else.
// PARAMETERS
//  ADDR_W   16            word-index width; DEPTH = 2**ADDR_W words (256 KiB default)
//  BASE     32'h0000_0000 physical byte address of word 0; window = [BASE, BASE + 4*DEPTH)
//  CNT_W    16            width of out-of-range access counter
// PORTS
//  clk              in   1      single clock, all state on posedge
//  rst_n            in   1      asynchronous, active-low reset
//  data_sram_en     in   1      access enable, high active
//  data_sram_wen    in   4      byte write enables; lane i = wdata[8i+7:8i]
//  data_sram_addr   in   32     physical byte address; bits [1:0] ignored
//  data_sram_wdata  in   32     write data
//  data_sram_rdata  out  32     read data, registered, valid the cycle after en
//  sram_ready       out  1      high when array accepts accesses
//  oor_cnt          out  CNT_W  saturating count of out-of-range accesses
// BEHAVIOUR
//  - Reset values: data_sram_rdata=0, oor_cnt=0, sram_ready per CONFIGURATION. Array contents are not reset.
//  - Decode:
//    - in_range = (addr - BASE) < 4*DEPTH, compared as unsigned 32-bit (wrap below BASE is out of range).
//    - idx = (addr - BASE)[ADDR_W+1:2].
//  - Cycle with en=1 and sram_ready=1 and in_range:
//    - Write: for each lane with wen[i]=1, mem[idx] lane i <= wdata lane i at posedge.
//    - Read: rdata <= merged word at posedge. Write-first: lanes written this cycle show new data; others show old.
//  - Cycle with en=1 and sram_ready=1 and out of range:
//    - No array update; rdata <= 0.
//    - oor_cnt <= oor_cnt+1, saturating at all-ones (no wrap).
//  - en=0: no array update; rdata holds its previous value; oor_cnt unchanged.
//  - en=1 while sram_ready=0: write dropped, rdata <= 0, oor_cnt unchanged (even if out of range).
//  - Latency: read data is visible exactly 1 cycle after the request. No backpressure toward the MEM stage.
//  - Back-to-back write then read of the same word:
//    - Second cycle sees the first write's data.
//    - No hazard bubble is permitted.
//  - Reset asserted mid-operation:
//    - rdata and oor_cnt clear immediately (async).
//    - The in-flight write is lost; the array keeps its other contents.
// CONFIGURATION
//  DATA_SRAM_CLEAR_EN defined:
//   - 2-state FSM {ST_CLEAR, ST_RUN}; reset -> ST_CLEAR with clear_idx=0, sram_ready=0.
//   - ST_CLEAR: mem[clear_idx] <= 0 each cycle, clear_idx++.
//   - At clear_idx == DEPTH-1: write 0, go to ST_RUN next cycle, sram_ready=1.
//   - Clear takes exactly DEPTH cycles after rst_n rises.
//   - Reset during ST_CLEAR restarts the sweep at index 0.
//  DATA_SRAM_CLEAR_EN undefined:
//   - No FSM, no clear counter; sram_ready tied 1 (also 1 in reset).
//   - Array powers up undefined.
// STRUCTURE
//  - defines.vh holds:
//    - DSRAM_ST_CLEAR/DSRAM_ST_RUN encodings (1-bit).
//    - Default ADDR_W / BASE / CNT_W values.
//    - Macro for the 4-lane byte merge mask.
//  - One sub-module dsram_array:
//    - DEPTH x 32 storage, 4 byte write enables.
//    - Combinational read of idx.
//  - The top holds decode, write-first merge, rdata register, oor counter and the optional clear FSM.
// TESTING
//  1. Write 0xDEADBEEF, wen=4'hF, @BASE+0x10; next cycle read same -> rdata=0xDEADBEEF one cycle later.
//  2. Byte-lane partial writes:
//     - Preload 0x11223344; write wen=4'b0010, wdata=0x0000AA00 -> read gives 0x1122AA44.
//     - Same cycle read+write gives the merged value.
//  3. Out-of-range handling:
//     - Access BASE-4 and BASE+4*DEPTH -> rdata=0, array unchanged, oor_cnt=2.
//     - Force 2**CNT_W+3 out-of-range accesses -> oor_cnt stays all-ones.
//  4. en=0 for 5 cycles after a read of 0x5A5A5A5A -> rdata holds 0x5A5A5A5A; writes with en=0 leave memory unchanged.
//  5. Async reset mid-stream:
//     - Pulse rst_n low between clock edges -> rdata=0 and oor_cnt=0 immediately.
//     - Previously written words still read back.
//  6. DATA_SRAM_CLEAR_EN build, ADDR_W=4:
//     - sram_ready rises exactly 16 cycles after rst_n; all words read 0.
//     - Writes during clear are dropped.
//     - Reset at cycle 8 restarts the 16-cycle sweep.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: shared defaults, clear-FSM state encodings and byte-lane mask helper
package data_sram_responder_pkg;
  localparam int          DSRAM_ADDR_W = 16;
  localparam logic [31:0] DSRAM_BASE   = 32'h0000_0000;
  localparam int          DSRAM_CNT_W  = 16;
  typedef enum logic {DSRAM_ST_CLEAR = 1'b0, DSRAM_ST_RUN = 1'b1} dsram_st_e;
  function automatic logic [31:0] byte_mask(input logic [3:0] wen);
    return {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  endfunction
endpackage

// File: rtl/data_sram_responder_array.sv
// dsram_array: DEPTH x 32 data storage with per-byte write enables and combinational read
module dsram_array #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: word-addressed data RAM responder with write-first reads and out-of-range counter
// Define DATA_SRAM_CLEAR_EN to zero the array after reset before accepting accesses.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          ADDR_W = DSRAM_ADDR_W,
  parameter logic [31:0] BASE   = DSRAM_BASE,
  parameter int          CNT_W  = DSRAM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  output logic             sram_ready,
  output logic [CNT_W-1:0] oor_cnt
);
  logic [31:0] off, rd, mask, merged, arr_wdata, rdata_q, rdata_d;
  logic [ADDR_W-1:0] idx, arr_idx;
  logic [3:0] arr_we;
  logic in_range, acc, hit;
  logic [CNT_W-1:0] oor_q, oor_d;
  // Subtracting BASE first makes addresses below the window wrap high and fail the compare.
  assign off      = data_sram_addr - BASE;
  assign in_range = 64'(off) < (64'd4 << ADDR_W);
  assign idx      = off[ADDR_W+1:2];
  assign acc      = data_sram_en & sram_ready;
  assign hit      = acc & in_range;
  assign mask     = byte_mask(data_sram_wen);
  assign merged   = (data_sram_wdata & mask) | (rd & ~mask);
  always_comb begin
    rdata_d = !data_sram_en ? rdata_q : hit ? merged : '0;
    oor_d   = (acc && !in_range && !(&oor_q)) ? oor_q + 1'b1 : oor_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata_q <= '0;
      oor_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      oor_q   <= oor_d;
    end
`ifdef DATA_SRAM_CLEAR_EN
  dsram_st_e st_q;
  logic [ADDR_W-1:0] clr_q;
  logic ready_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q    <= DSRAM_ST_CLEAR;
      clr_q   <= '0;
      ready_q <= 1'b0;
    end else if (st_q == DSRAM_ST_CLEAR) begin
      clr_q <= clr_q + 1'b1;
      if (&clr_q) begin
        st_q    <= DSRAM_ST_RUN;
        ready_q <= 1'b1;
      end
    end
  assign sram_ready = ready_q;
  assign arr_we     = !rst_n ? 4'h0 : (st_q == DSRAM_ST_CLEAR) ? 4'hF : hit ? data_sram_wen : 4'h0;
  assign arr_idx    = (st_q == DSRAM_ST_CLEAR) ? clr_q : idx;
  assign arr_wdata  = (st_q == DSRAM_ST_CLEAR) ? 32'h0 : data_sram_wdata;
`else
  assign sram_ready = 1'b1;
  // Gating with rst_n drops a write whose edge lands while reset is held.
  assign arr_we     = (rst_n && hit) ? data_sram_wen : 4'h0;
  assign arr_idx    = idx;
  assign arr_wdata  = data_sram_wdata;
`endif
  dsram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk  (clk),
    .we   (arr_we),
    .idx  (arr_idx),
    .wdata(arr_wdata),
    .rdata(rd)
  );
  assign data_sram_rdata = rdata_q;
  assign oor_cnt         = oor_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: table-driven checks plus reset, saturation and optional clear-sweep sequences
module tb_data_sram_responder;
  localparam int          ADDR_W = 4;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          CNT_W  = 4;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, ready;
  logic [3:0] wen = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0, rdata;
  logic [CNT_W-1:0] oor;
  int total = 0, passed = 0;
  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_oor;
  } vec_t;
  vec_t vecs [17];
  data_sram_responder #(.ADDR_W(ADDR_W), .BASE(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .sram_ready(ready), .oor_cnt(oor)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input string name, input int exp_cycles);
    int n = 0;
    while (!ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(n), 32'(exp_cycles));
  endtask
  initial begin
    vecs = '{
      '{1'b1, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd0},
      '{1'b1, 4'h0, 32'h1000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 4'd0},
      '{1'b1, 4'hF, 32'h1000_0020, 32'h1122_3344, 32'h1122_3344, 4'd0},
      '{1'b1, 4'h2, 32'h1000_0020, 32'h0000_AA00, 32'h1122_AA44, 4'd0},
      '{1'b1, 4'h0, 32'h1000_0022, 32'hFFFF_FFFF, 32'h1122_AA44, 4'd0},
      '{1'b1, 4'h8, 32'h1000_0020, 32'h9900_0000, 32'h9922_AA44, 4'd0},
      '{1'b1, 4'hF, 32'h0FFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000, 4'd1},
      '{1'b1, 4'hF, 32'h1000_0040, 32'hFFFF_FFFF, 32'h0000_0000, 4'd2},
      '{1'b1, 4'hF, 32'h1000_003C, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 4'd2},
      '{1'b0, 4'hF, 32'h1000_003C, 32'h0000_0000, 32'h5A5A_5A5A, 4'd2},
      '{1'b0, 4'hF, 32'h1000_0010, 32'h1111_1111, 32'h5A5A_5A5A, 4'd2},
      '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h5A5A_5A5A, 4'd2},
      '{1'b0, 4'h3, 32'h1000_0020, 32'h2222_2222, 32'h5A5A_5A5A, 4'd2},
      '{1'b0, 4'hF, 32'h1000_003C, 32'h3333_3333, 32'h5A5A_5A5A, 4'd2},
      '{1'b1, 4'h0, 32'h1000_003C, 32'h0000_0000, 32'h5A5A_5A5A, 4'd2},
      '{1'b1, 4'h0, 32'h1000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 4'd2},
      '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 4'd3}
    };
    #2;
    check("reset_rdata", rdata, 32'h0);
    check("reset_oor", 32'(oor), 32'h0);
`ifdef DATA_SRAM_CLEAR_EN
    check("reset_ready", 32'(ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; wen = 4'hF; addr = BASE; wdata = 32'hFFFF_FFFF;
    wait_ready("clear_cycles", 16);
    check("clear_rdata_dropped", rdata, 32'h0);
    check("clear_oor_unchanged", 32'(oor), 32'h0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'h0, BASE + 32'(4*i), 32'h0);
      check($sformatf("cleared_word_%0d", i), rdata, 32'h0);
    end
    step(1'b1, 4'hF, BASE + 32'h8, 32'hCAFE_F00D);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;
    check("restart_ready_low", 32'(ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    wait_ready("restart_cycles", 16);
    step(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    check("restart_cleared", rdata, 32'h0);
`else
    check("reset_ready", 32'(ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
`endif
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_oor", i), 32'(oor), 32'(vecs[i].exp_oor));
    end
    @(negedge clk);
    en = 1'b1; wen = 4'hF; addr = 32'h1000_0010; wdata = 32'h0000_0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rdata", rdata, 32'h0);
    check("async_oor", 32'(oor), 32'h0);
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
`ifdef DATA_SRAM_CLEAR_EN
    wait_ready("reclear_cycles", 16);
    step(1'b1, 4'h0, 32'h1000_0010, 32'h0);
    check("post_reset_word10", rdata, 32'h0);
`else
    step(1'b1, 4'h0, 32'h1000_0010, 32'h0);
    check("post_reset_word10", rdata, 32'hDEAD_BEEF);
    step(1'b1, 4'h0, 32'h1000_0020, 32'h0);
    check("post_reset_word20", rdata, 32'h9922_AA44);
`endif
    for (int i = 1; i <= 19; i++) begin
      step(1'b1, (i % 2) ? 4'hF : 4'h0, 32'h1000_0040, 32'hFFFF_FFFF);
      if (i == 14) check("sat_count14", 32'(oor), 32'd14);
    end
    check("sat_all_ones", 32'(oor), 32'd15);
    check("sat_rdata", rdata, 32'h0);
    step(1'b1, 4'h0, 32'h1000_003C, 32'h0);
`ifdef DATA_SRAM_CLEAR_EN
    check("oor_no_write", rdata, 32'h0);
`else
    check("oor_no_write", rdata, 32'h5A5A_5A5A);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
